compressor_env: RTL and testbench
=================================

// Module: compressor_env
// PURPOSE
// - Envelope-driven dynamic-range compressor for the pedal's signed audio path.
//   Parametrised successor of the combinational compressor.
// - Peak envelope follower with runtime attack/release. Gain reduction is computed from the envelope, not the instantaneous sample.
// - Valid-qualified 3-stage pipeline. Sits between the input filter and the effects mixer.
// PARAMETERS
// - DATA_W  16  sample width, two's complement; all arithmetic in DATA_W unless noted.
// - CTRL_W  8   threshold/ratio width; thr_mag = {1'b0, threshold, (DATA_W-1-CTRL_W)'b0}.
// - SHIFT_W 4   width of attack_shift/release_shift.
// PORTS
// - clk            in   1        system clock; all logic on rising edge.
// - rst            in   1        synchronous, active-high reset.
// - in_valid       in   1        audio_in is a new sample this cycle; may be high every cycle.
// - audio_in       in   DATA_W   signed input sample.
// - threshold      in   CTRL_W   compression knee, unsigned magnitude (scaling above).
// - ratio          in   CTRL_W   kept slope, Q0.CTRL_W: 0 = hard limit, 2^CTRL_W-1 = almost no compression.
// - attack_shift   in   SHIFT_W  envelope rise = (mag-env)>>attack_shift; 0 = instant.
// - release_shift  in   SHIFT_W  envelope fall = (env-mag)>>release_shift.
// - out_valid      out  1        audio_out is valid this cycle.
// - audio_out      out  DATA_W   signed compressed sample.
// - env_out        out  DATA_W-1 current envelope magnitude, for the level meter.
// BEHAVIOUR
// - Reset: out_valid=0, audio_out=0, env_out=0, all pipeline valids and registers cleared.
//   Applies mid-stream: in-flight samples are dropped and no out_valid pulse follows.
// - Latency: exactly 3 cycles from in_valid to out_valid, 1 sample/cycle throughput.
//   Without in_valid, stages hold their data and valid bits shift to 0. No stalls, no backpressure.
// - S1, on in_valid:
//   - sign = audio_in[DATA_W-1].
//   - mag = |audio_in|; the most negative code saturates to 2^(DATA_W-1)-1.
//   - Envelope update: if mag>env, env += (mag-env)>>attack_shift; else env -= (env-mag)>>release_shift.
//   - env changes only on in_valid; it never exceeds 2^(DATA_W-1)-1 and never goes below 0.
// - S2:
//   - excess = (env>thr_mag) ? env-thr_mag : 0.
//   - red = (excess * (2^CTRL_W - ratio)) >> CTRL_W. The product is full width (DATA_W+CTRL_W) before the shift.
// - S3:
//   - out_mag = (red>=mag) ? 0 : mag-red, so the output never crosses zero.
//   - audio_out = sign ? -out_mag : out_mag. out_valid = S2 valid.
// - Runtime inputs are sampled in the stage that uses them:
//   - threshold and ratio in S2; attack_shift and release_shift in S1.
//   - A change takes effect on the next valid sample and needs no flush.
// - Boundaries:
//   - env <= thr_mag -> output equals input (bit-exact passthrough), except the most negative input returns -(2^(DATA_W-1)-1).
//   - threshold = 0 -> whole signal is compressed.
//   - ratio = 0 -> red = excess.
// CONFIGURATION
// - COMP_MAKEUP_GAIN_EN defined:
//   - Adds input port makeup [7:0], unsigned Q4.4, sampled in S3.
//   - S3 computes out_mag = min((out_mag*makeup)>>4, 2^(DATA_W-1)-1) before the sign is restored.
//   - Latency stays 3. makeup = 8'h10 is unity gain.
// - COMP_MAKEUP_GAIN_EN undefined: no makeup port and no multiplier; out_mag is used directly.
// TESTING (DATA_W=16, CTRL_W=8)
// - Reset: rst=1 for 2 cycles, then in_valid pulses -> out_valid=0 and audio_out=0 during reset; first out_valid 3 cycles after the first post-reset in_valid.
// - Compression: threshold=8'h40 (thr 0x2000), ratio=8'h80, attack_shift=0, audio_in=0x6000 streamed.
//   - env=0x6000, red=0x2000 -> audio_out=0x4000, 3 cycles after each in_valid.
// - Negative and saturation, same settings:
//   - audio_in=0xA000 -> audio_out=0xC000.
//   - audio_in=0x8000 -> env=0x7FFF, red=0x2FFF, audio_out=0xB000.
// - Release: env=0x6000, then audio_in=0 with release_shift=4.
//   - env_out goes 0x5A00, 0x5460, ... on successive in_valid only.
//   - audio_out=0 throughout (red>=mag clamps to 0).
// - Below threshold: threshold=8'h7F, ratio=0 -> random samples with |x|<0x3F00 pass through bit-exact.
//   - Gap cycles between in_valid pulses produce no extra out_valid pulses.
// - Mid-stream reset: rst=1 one cycle while 3 samples are in flight -> no out_valid for them; env_out=0 on the next cycle.
//   - With COMP_MAKEUP_GAIN_EN, makeup=8'h20 and the 0x6000 case above -> 0x7FFF (saturated).

Source files
------------

// File: rtl/compressor_env.sv
// Envelope-driven dynamic-range compressor for the signed audio path.
// Three registered stages: S1 magnitude + peak envelope follower, S2 gain
// reduction from the envelope, S3 reduction applied and sign restored.
// Optional makeup gain in S3 is built when COMP_MAKEUP_GAIN_EN is defined.
module compressor_env #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  audio_in,
    input  logic [CTRL_W-1:0]  threshold,
    input  logic [CTRL_W-1:0]  ratio,
    input  logic [SHIFT_W-1:0] attack_shift,
    input  logic [SHIFT_W-1:0] release_shift,
`ifdef COMP_MAKEUP_GAIN_EN
    input  logic [7:0]         makeup,
`endif
    output logic               out_valid,
    output logic [DATA_W-1:0]  audio_out,
    output logic [DATA_W-2:0]  env_out
);

    localparam int unsigned MAG_W  = DATA_W - 1;
    localparam int unsigned PROD_W = DATA_W + CTRL_W;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    // ---------------------------------------------------------------- S1
    logic              s1_valid_q;
    logic              s1_sign_q;
    logic [MAG_W-1:0]  s1_mag_q;
    logic [MAG_W-1:0]  env_q;
    logic [MAG_W-1:0]  env_d;
    logic [MAG_W-1:0]  in_mag;
    logic [DATA_W-1:0] in_neg;

    // Magnitude with the most negative code clamped, then peak-follower step.
    // A rise never overshoots mag and a fall never undershoots it, so env
    // stays inside [0, MAG_MAX] without extra saturation.
    always_comb begin
        in_neg = '0 - audio_in;
        if (audio_in == {1'b1, {MAG_W{1'b0}}}) begin
            in_mag = MAG_MAX;
        end else if (audio_in[DATA_W-1]) begin
            in_mag = in_neg[MAG_W-1:0];
        end else begin
            in_mag = audio_in[MAG_W-1:0];
        end
        if (in_mag > env_q) begin
            env_d = env_q + ((in_mag - env_q) >> attack_shift);
        end else begin
            env_d = env_q - ((env_q - in_mag) >> release_shift);
        end
    end

    // S1 registers: capture sign/magnitude and advance the envelope on valid only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            env_q      <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= audio_in[DATA_W-1];
                s1_mag_q  <= in_mag;
                env_q     <= env_d;
            end
        end
    end

    assign env_out = env_q;

    // ---------------------------------------------------------------- S2
    logic              s2_valid_q;
    logic              s2_sign_q;
    logic [MAG_W-1:0]  s2_mag_q;
    logic [MAG_W-1:0]  s2_red_q;
    logic [MAG_W-1:0]  thr_mag;
    logic [MAG_W-1:0]  excess;
    logic [CTRL_W:0]   slope;
    logic [PROD_W-1:0] prod;
    logic [MAG_W-1:0]  red;
    logic              unused_prod;

    // Reduction = excess * (1 - ratio), full-width product before the shift.
    // slope <= 2^CTRL_W, so prod >> CTRL_W never exceeds excess and fits MAG_W.
    always_comb begin
        thr_mag     = {threshold, {(MAG_W - CTRL_W){1'b0}}};
        excess      = (env_q > thr_mag) ? (env_q - thr_mag) : '0;
        slope       = {1'b1, {CTRL_W{1'b0}}} - {1'b0, ratio};
        prod        = PROD_W'(excess) * PROD_W'(slope);
        red         = prod[CTRL_W +: MAG_W];
        unused_prod = ^{prod[PROD_W-1], prod[CTRL_W-1:0]};
    end

    // S2 registers: hold sample and reduction; data only moves on valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_mag_q   <= '0;
            s2_red_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_mag_q  <= s1_mag_q;
                s2_red_q  <= red;
            end
        end
    end

    // ---------------------------------------------------------------- S3
    logic              out_valid_q;
    logic [DATA_W-1:0] audio_out_q;
    logic [DATA_W-1:0] audio_out_d;
    logic [MAG_W-1:0]  out_mag;
    logic [MAG_W-1:0]  final_mag;
`ifdef COMP_MAKEUP_GAIN_EN
    logic [MAG_W+7:0]  scaled;
    logic              unused_scaled;
`endif

    // Apply reduction without crossing zero, optional Q4.4 makeup, restore sign.
    always_comb begin
        out_mag = (s2_red_q >= s2_mag_q) ? '0 : (s2_mag_q - s2_red_q);
`ifdef COMP_MAKEUP_GAIN_EN
        scaled        = (MAG_W + 8)'(out_mag) * (MAG_W + 8)'(makeup);
        unused_scaled = ^scaled[3:0];
        if (scaled[MAG_W+7:4] > (MAG_W + 4)'(MAG_MAX)) begin
            final_mag = MAG_MAX;
        end else begin
            final_mag = scaled[4 +: MAG_W];
        end
`else
        final_mag = out_mag;
`endif
        audio_out_d = s2_sign_q ? ('0 - {1'b0, final_mag}) : {1'b0, final_mag};
    end

    // Output registers: audio_out holds its last value between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            audio_out_q <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                audio_out_q <= audio_out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign audio_out = audio_out_q;

endmodule

// File: tb/tb_compressor_env.sv
// Directed self-checking bench for compressor_env (DATA_W=16, CTRL_W=8).
// Builds with or without COMP_MAKEUP_GAIN_EN.
module tb_compressor_env;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] audio_in;
    logic [7:0]  threshold;
    logic [7:0]  ratio;
    logic [3:0]  attack_shift;
    logic [3:0]  release_shift;
`ifdef COMP_MAKEUP_GAIN_EN
    logic [7:0]  makeup;
`endif
    logic        out_valid;
    logic [15:0] audio_out;
    logic [14:0] env_out;

    int total = 0;
    int bad   = 0;

    compressor_env dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .audio_in      (audio_in),
        .threshold     (threshold),
        .ratio         (ratio),
        .attack_shift  (attack_shift),
        .release_shift (release_shift),
`ifdef COMP_MAKEUP_GAIN_EN
        .makeup        (makeup),
`endif
        .out_valid     (out_valid),
        .audio_out     (audio_out),
        .env_out       (env_out)
    );

    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated sample: envelope after S1, held during the gap, output
    // exactly three cycles later, then no extra valid pulse.
    task automatic run_one(input string tag, input logic [15:0] x,
                           input logic [15:0] exp_out, input logic [14:0] exp_env);
        in_valid = 1'b1;
        audio_in = x;
        tick();
        in_valid = 1'b0;
        chk({tag, "_env"}, 32'(env_out), 32'(exp_env));
        chk({tag, "_v1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_envhold"}, 32'(env_out), 32'(exp_env));
        chk({tag, "_v2"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_v3"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(audio_out), 32'(exp_out));
        tick();
        chk({tag, "_v4"}, 32'(out_valid), 32'd0);
        chk({tag, "_outhold"}, 32'(audio_out), 32'(exp_out));
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b1;
        audio_in      = 16'h6000;
        threshold     = 8'h40;
        ratio         = 8'h80;
        attack_shift  = 4'd0;
        release_shift = 4'd0;
`ifdef COMP_MAKEUP_GAIN_EN
        makeup        = 8'h10;
`endif

        // Reset held for two cycles with in_valid pulsing.
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(audio_out), 32'd0);
        chk("rst_env", 32'(env_out), 32'd0);
        tick();
        chk("rst_valid2", 32'(out_valid), 32'd0);
        chk("rst_out2", 32'(audio_out), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        // Compression: thr 0x2000, ratio 1/2, instant attack.
        run_one("comp", 16'h6000, 16'h4000, 15'h6000);

        // Streamed at full rate: outputs on cycles 3..6 after the first sample.
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 4);
            audio_in = 16'h6000;
            tick();
            chk("stream_valid", 32'(out_valid), 32'((i >= 2) && (i <= 5)));
            if ((i >= 2) && (i <= 5)) chk("stream_out", 32'(audio_out), 32'h4000);
        end
        in_valid = 1'b0;

        // Negative and saturating inputs.
        run_one("neg", 16'hA000, 16'hC000, 15'h6000);
        run_one("sat", 16'h8000, 16'hB000, 15'h7FFF);

        // Release from 0x6000 with release_shift=4; output clamps to zero.
        run_one("relset", 16'h6000, 16'h4000, 15'h6000);
        release_shift = 4'd4;
        run_one("rel1", 16'h0000, 16'h0000, 15'h5A00);
        run_one("rel2", 16'h0000, 16'h0000, 15'h5460);
        run_one("rel3", 16'h0000, 16'h0000, 15'h4F1A);

        // Below threshold (thr 0x3F80, ratio 0): bit-exact passthrough.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        threshold = 8'h7F;
        ratio     = 8'h00;
        run_one("pass1", 16'h1234, 16'h1234, 15'h1234);
        run_one("pass2", 16'hC101, 16'hC101, 15'h3EFF);
        run_one("pass3", 16'h3EFF, 16'h3EFF, 15'h3EFF);
        run_one("pass4", 16'h0001, 16'h0001, 15'h3B10);
        run_one("pass5", 16'hFFFF, 16'hFFFF, 15'h3760);
        run_one("pass6", 16'h0000, 16'h0000, 15'h33EA);
        run_one("pass7", 16'hE000, 16'hE000, 15'h32AC);

        // threshold = 0: whole signal compressed; ratio 0 removes it entirely.
        threshold = 8'h00;
        ratio     = 8'h80;
        run_one("thr0", 16'h7000, 16'h3800, 15'h7000);
        ratio = 8'h00;
        run_one("ratio0", 16'h7000, 16'h0000, 15'h7000);

        // Slow attack: env rises by a quarter of the gap.
        threshold    = 8'h40;
        ratio        = 8'h80;
        attack_shift = 4'd2;
        run_one("attack", 16'h7FFF, 16'h5600, 15'h73FF);
        attack_shift = 4'd0;

        // Mid-stream reset with three samples in flight.
        in_valid = 1'b1;
        audio_in = 16'h6000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_env", 32'(env_out), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", 32'(audio_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_drop", 32'(out_valid), 32'd0);
        end

`ifdef COMP_MAKEUP_GAIN_EN
        // 2x makeup saturates the 0x4000 result.
        makeup = 8'h20;
        run_one("makeup", 16'h6000, 16'h7FFF, 15'h6000);
        makeup = 8'h10;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
